// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants for the uart echo buffer
// Purpose: echo FSM state encoding, echo mode codes and ASCII constants
//          used by the case transform.
// Ports:   none (package)
package uart_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_TRIG = 2'd2,
      ST_WAIT = 2'd3
   } state_t;

   localparam logic [1:0] MODE_RAW   = 2'd0;
   localparam logic [1:0] MODE_UPPER = 2'd1;
   localparam logic [1:0] MODE_LINE  = 2'd2;

   localparam logic [7:0] CH_a     = 8'h61;
   localparam logic [7:0] CH_z     = 8'h7A;
   localparam logic [7:0] CASE_OFS = 8'h20;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - synchronous FIFO with registered read data
// Purpose: single-clock FIFO; writes when full and reads when empty are
//          ignored. Read data appears one cycle after i_rd_en.
// Ports:   i_clk, i_rst (sync, active-high)
//          i_wr_en/i_wr_data  push side
//          i_rd_en/o_rd_data  pop side, o_rd_data registered
//          o_full, o_empty, o_level (occupancy, 0..DEPTH)
module sync_fifo #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 16
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic                    i_wr_en,
   input  logic [DATA_W-1:0]       i_wr_data,
   input  logic                    i_rd_en,
   output logic [DATA_W-1:0]       o_rd_data,
   output logic                    o_full,
   output logic                    o_empty,
   output logic [$clog2(DEPTH):0]  o_level
);

   localparam int ADDR_W = $clog2(DEPTH);

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [ADDR_W:0]   r_wr_ptr;
   logic [ADDR_W:0]   r_rd_ptr;
   logic [DATA_W-1:0] r_rd_data;
   logic              w_wr;
   logic              w_rd;

   // Extra pointer MSB distinguishes full from empty when the indices match.
   assign o_full  = (r_wr_ptr[ADDR_W] != r_rd_ptr[ADDR_W]) &&
                    (r_wr_ptr[ADDR_W-1:0] == r_rd_ptr[ADDR_W-1:0]);
   assign o_empty = (r_wr_ptr == r_rd_ptr);
   assign o_level = r_wr_ptr - r_rd_ptr;

   assign w_wr = i_wr_en && !o_full;
   assign w_rd = i_rd_en && !o_empty;

   assign o_rd_data = r_rd_data;

   always_ff @(posedge i_clk) begin
      if (w_wr) begin
         r_mem[r_wr_ptr[ADDR_W-1:0]] <= i_wr_data;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_wr_ptr  <= '0;
         r_rd_ptr  <= '0;
         r_rd_data <= '0;
      end else begin
         if (w_wr) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_rd) begin
            r_rd_data <= r_mem[r_rd_ptr[ADDR_W-1:0]];
            r_rd_ptr  <= r_rd_ptr + 1'b1;
         end
      end
   end

endmodule

// File: rtl/uart_echo_buf.sv
// rtl/uart_echo_buf.sv - buffered rx-to-tx echo with modes and error flags
// Purpose: queues received bytes and replays them to the transmitter one
//          frame at a time, optionally upper-casing or holding until a
//          complete line is buffered. Flags overflow and tx timeout.
// Ports:   i_sclk, i_rst (sync, active-high)
//          i_mode        0 raw, 1 uppercase, 2 line, 3 raw
//          i_rx_done/i_rx_byte    received byte strobe
//          o_tx_trigger/o_tx_byte frame start pulse and byte
//          i_tx_done     frame finished pulse
//          o_fifo_level  occupancy
//          o_ovf, o_tx_err sticky flags, cleared by i_err_clr
module uart_echo_buf
   import uart_pkg::*;
#(
   parameter int                DATA_W     = 8,
   parameter int                DEPTH      = 16,
   parameter logic [DATA_W-1:0] EOL_CHAR   = 'h0D,
   parameter int                TX_TIMEOUT = 50000
) (
   input  logic                   i_sclk,
   input  logic                   i_rst,
   input  logic [1:0]             i_mode,
   input  logic                   i_rx_done,
   input  logic [DATA_W-1:0]      i_rx_byte,
   output logic                   o_tx_trigger,
   output logic [DATA_W-1:0]      o_tx_byte,
   input  logic                   i_tx_done,
   output logic [$clog2(DEPTH):0] o_fifo_level,
   output logic                   o_ovf,
   output logic                   o_tx_err,
   input  logic                   i_err_clr
);

   localparam int LVL_W = $clog2(DEPTH) + 1;
   localparam int CNT_W = $clog2(TX_TIMEOUT) + 1;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [1:0]        r_mode_q;
   logic [DATA_W-1:0] r_tx_byte;
   logic [CNT_W-1:0]  r_tmo_cnt;
   logic [LVL_W-1:0]  r_line_cnt;
   logic              r_ovf;
   logic              r_tx_err;

   logic [DATA_W-1:0] w_rd_data;
   logic [DATA_W-1:0] w_xform;
   logic              w_full;
   logic              w_empty;
   logic              w_push;
   logic              w_drop;
   logic              w_pop;
   logic              w_timeout;
   logic              w_release_ok;
   logic              w_eol_in;
   logic              w_eol_out;

   sync_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_fifo (
      .i_clk     (i_sclk),
      .i_rst     (i_rst),
      .i_wr_en   (i_rx_done),
      .i_wr_data (i_rx_byte),
      .i_rd_en   (w_pop),
      .o_rd_data (w_rd_data),
      .o_full    (w_full),
      .o_empty   (w_empty),
      .o_level   (o_fifo_level)
   );

   // A full FIFO drops the byte even if a pop frees a slot this cycle.
   assign w_push = i_rx_done && !w_full;
   assign w_drop = i_rx_done && w_full;

   // Release decision uses the live mode because IDLE is where mode is taken.
   // In line mode a full FIFO lets exactly one byte out so input can resume.
   always_comb begin
      w_release_ok = 1'b0;
      case (i_mode)
         MODE_RAW, MODE_UPPER: w_release_ok = !w_empty;
         MODE_LINE:            w_release_ok = !w_empty && ((r_line_cnt != '0) || w_full);
         default:              w_release_ok = !w_empty;
      endcase
   end

   always_comb begin
      w_state_nxt = r_state;
      w_pop       = 1'b0;
      w_timeout   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_release_ok) begin
               w_pop       = 1'b1;
               w_state_nxt = ST_LOAD;
            end
         end
         ST_LOAD: w_state_nxt = ST_TRIG;
         ST_TRIG: w_state_nxt = ST_WAIT;
         ST_WAIT: begin
            // The counter reaches TX_TIMEOUT-1 on this edge, so tx_err rises
            // exactly TX_TIMEOUT edges after the one that raised tx_trigger.
            if (i_tx_done) begin
               w_state_nxt = ST_IDLE;
            end else if (r_tmo_cnt == CNT_W'(TX_TIMEOUT - 2)) begin
               w_timeout   = 1'b1;
               w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_sclk) begin
      if (i_rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_xform = w_rd_data;
      if ((r_mode_q == MODE_UPPER) && (w_rd_data != EOL_CHAR) &&
          (w_rd_data >= DATA_W'(CH_a)) && (w_rd_data <= DATA_W'(CH_z))) begin
         w_xform = w_rd_data - DATA_W'(CASE_OFS);
      end
   end

   always_ff @(posedge i_sclk) begin
      if (i_rst) begin
         r_mode_q  <= MODE_RAW;
         r_tx_byte <= '0;
         r_tmo_cnt <= '0;
      end else begin
         if (r_state == ST_IDLE) begin
            r_mode_q <= i_mode;
         end
         if (r_state == ST_LOAD) begin
            r_tx_byte <= w_xform;
         end
         if (r_state == ST_TRIG) begin
            r_tmo_cnt <= '0;
         end else if (r_state == ST_WAIT) begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
         end
      end
   end

   // Popped data is visible in LOAD, so the EOL decrement lands there; it
   // always completes before the next IDLE release decision.
   assign w_eol_in  = w_push && (i_rx_byte == EOL_CHAR);
   assign w_eol_out = (r_state == ST_LOAD) && (w_rd_data == EOL_CHAR);

   always_ff @(posedge i_sclk) begin
      if (i_rst) begin
         r_line_cnt <= '0;
      end else begin
         case ({w_eol_in, w_eol_out})
            2'b10: if (r_line_cnt != LVL_W'(DEPTH)) r_line_cnt <= r_line_cnt + 1'b1;
            2'b01: if (r_line_cnt != '0) r_line_cnt <= r_line_cnt - 1'b1;
            default: r_line_cnt <= r_line_cnt;
         endcase
      end
   end

   // Sticky flags: a new event in the same cycle as err_clr keeps the flag set.
   always_ff @(posedge i_sclk) begin
      if (i_rst) begin
         r_ovf    <= 1'b0;
         r_tx_err <= 1'b0;
      end else begin
         if (w_drop) begin
            r_ovf <= 1'b1;
         end else if (i_err_clr) begin
            r_ovf <= 1'b0;
         end
         if (w_timeout) begin
            r_tx_err <= 1'b1;
         end else if (i_err_clr) begin
            r_tx_err <= 1'b0;
         end
      end
   end

   assign o_tx_trigger = (r_state == ST_TRIG);
   assign o_tx_byte    = r_tx_byte;
   assign o_ovf        = r_ovf;
   assign o_tx_err     = r_tx_err;

endmodule

// File: doc/uart_echo_buf.md
Name: uart_echo_buf

Overview:
Parametrised successor to the direct rx_done→tx_trigger loopback. It sits between the rx and tx sides of uart_ctrler. Received bytes go into a FIFO, so back-to-back frames are not lost while the transmitter is busy. Selectable modes transform or line-buffer the echoed bytes, and the block reports overflow and transmit timeout.

Parameters:
DATA_W, 8, byte width on rx/tx paths
DEPTH, 16, FIFO entries; power of two, ≥2
EOL_CHAR, 8'h0D, line terminator for line mode
TX_TIMEOUT, 50000, max sclk cycles from tx_trigger to tx_done (≥ one 115200-baud frame at 50 MHz ≈ 4340)

Ports:
sclk  in  1  system clock
rst  in  1  synchronous reset, active-high
mode  in  2  0 raw echo, 1 uppercase echo, 2 line mode, 3 = raw
rx_done  in  1  one-cycle pulse, rx_byte valid
rx_byte  in  DATA_W  received byte
tx_trigger  out  1  one-cycle pulse to start a frame
tx_byte  out  DATA_W  byte to send; stable from tx_trigger until tx_done
tx_done  in  1  one-cycle pulse, frame finished
fifo_level  out  $clog2(DEPTH)+1  current occupancy
ovf  out  1  sticky: byte dropped because FIFO was full
tx_err  out  1  sticky: tx_done not seen within TX_TIMEOUT
err_clr  in  1  clears ovf and tx_err

Behaviour:
- Reset (sync, rst=1 at a sclk edge) forces these values: tx_trigger=0, tx_byte=0, fifo_level=0, ovf=0, tx_err=0, line_cnt=0, state IDLE, FIFO pointers 0. Reset mid-frame abandons the frame without waiting for tx_done.
- Write: rx_done=1 and level<DEPTH → push rx_byte. rx_done=1 and level==DEPTH → drop byte, set ovf, even if a pop occurs in the same cycle.
- Pop and write in the same cycle: level unchanged.
- err_clr and a new error event in the same cycle: the set wins.
- The state machine has four states:
  - IDLE: samples mode into mode_q. If release_ok, issue a pop and go to LOAD.
  - LOAD: the FIFO read data (registered, 1-cycle) is valid. Transform it into tx_byte. Go to TRIG.
  - TRIG: tx_trigger=1 for exactly this cycle. Clear the timeout counter. Go to WAIT.
  - WAIT: on tx_done go to IDLE. If the counter reaches TX_TIMEOUT-1 without tx_done, set tx_err and go to IDLE.
- tx_done outside WAIT is ignored.
- release_ok:
  - Modes 0/1/3: FIFO not empty.
  - Mode 2: FIFO not empty and (line_cnt>0, or FIFO full — forced flush of one byte per full condition).
- line_cnt counter:
  - Increments when EOL_CHAR is pushed.
  - Decrements when EOL_CHAR is popped.
  - Push and pop of EOL in the same cycle leave it unchanged.
  - A dropped EOL is not counted.
  - Counts in all modes; saturates at DEPTH.
- Transform in LOAD:
  - mode_q=1 and byte in 8'h61..8'h7A → byte−8'h20.
  - Otherwise the byte passes unchanged.
  - EOL_CHAR is always echoed as is.
- Mode changes take effect only at the next IDLE; a frame in flight is not altered.
- Latency: with rx_done in cycle N, FIFO empty, state IDLE and mode 0/1 → tx_trigger in cycle N+3 (N: write; N+1: IDLE sees non-empty, pops; N+2: LOAD; N+3: TRIG).
- Throughput: one frame per tx_done + 3 cycles. There are no bubbles beyond that.
- fifo_level is registered and reflects pushes/pops one cycle later.
- Wrap-around: pointers are ADDR_W+1 bits. full = MSBs differ and LSBs equal; empty = pointers equal.

Decomposition:
- Shared package uart_pkg holds:
  - state encoding localparams ST_IDLE/ST_LOAD/ST_TRIG/ST_WAIT;
  - mode codes MODE_RAW=0, MODE_UPPER=1, MODE_LINE=2;
  - ASCII constants CH_a, CH_z, CASE_OFS=8'h20.
- One sub-module: sync_fifo (DATA_W, DEPTH). It provides a registered read, full/empty/level outputs and no read/write when illegal.
- The state machine, transform, line counter, timeout and sticky flags live in uart_echo_buf.

Test Plan:
1. Raw latency: mode=0, rx_done with 8'h41 in cycle 10 → tx_trigger in cycle 13, tx_byte=8'h41. After tx_done, state returns IDLE and level=0.
2. Burst buffering: 5 rx_done pulses 1 cycle apart (8'h31..8'h35), tx_done 4340 cycles after each trigger → five triggers in order 31,32,33,34,35; fifo_level peaks at 4; ovf=0.
3. Overflow: DEPTH=16, hold tx_done low (no pops after first), send 18 bytes → level 16 (+1 in flight). ovf=1 after byte 18; dropped byte is never sent. err_clr → ovf=0.
4. Uppercase: mode=1, send 'a','Z','{' (8'h61,8'h5A,8'h7B) → tx_byte 8'h41, 8'h5A, 8'h7B.
5. Line mode: mode=2, send "hi" → no tx_trigger after 1000 cycles. Send 8'h0D → three triggers 8'h68, 8'h69, 8'h0D; line_cnt returns 0.
6. Timeout/reset: never assert tx_done after a trigger → tx_err=1 exactly TX_TIMEOUT cycles after tx_trigger; next byte still sent. rst asserted in WAIT → all outputs 0 next cycle.
